frame_pack_ctrl: RTL and testbench
==================================

FRAME_PACK_CTRL -- requirements
Module: frame_pack_ctrl

Interface
REQ-001 Parameter FRAME_WORDS, default 240: 16-bit words per frame.
REQ-002 Parameter TIMEOUT_CYC, default 50000: idle cycles in FILL before the frame is aborted.
REQ-003 Port clk  in  1: single clock; all logic on the rising edge.
REQ-004 Port rst  in  1: synchronous, active-high reset.
REQ-005 Port word_in  in  16: incoming word from the UART receive path.
REQ-006 Port word_valid  in  1: word_in valid this cycle.
REQ-007 Port word_ready  out  1: controller accepts word_in this cycle.
REQ-008 Port pk_data  out  16: word forwarded to the 16-to-wide packer.
REQ-009 Port pk_valid  out  1: packer data_valid strobe.
REQ-010 Port pk_en  out  1: packer enable; low with pk_valid high clears the packer.
REQ-011 Port frame_valid  out  1: full frame present in packer, awaiting consumer.
REQ-012 Port frame_ack  in  1: consumer has taken the frame.
REQ-013 Port frame_err  out  1: one-cycle pulse on timeout abort.
REQ-014 Port word_cnt  out  8: words accepted in the current frame.
REQ-015 Port drop_cnt  out  8: words offered while word_ready low; saturates at 255.

Function
REQ-016 States IDLE, FILL, HOLD, FLUSH; encoding is free.
REQ-017 IDLE: word_ready=1; a handshake (word_valid & word_ready) forwards the word and enters FILL with word_cnt=1.
REQ-018 Forwarding a word: same cycle pk_data=word_in, pk_valid=1, pk_en=1; zero latency, combinational from word_in.
REQ-019 FILL: word_ready=1; each handshake increments word_cnt and resets the idle timer.
REQ-020 FILL: the handshake that makes word_cnt equal FRAME_WORDS enters HOLD next cycle.
REQ-021 HOLD: word_ready=0, pk_valid=0, frame_valid=1; remain in HOLD until frame_ack=1.
REQ-022 HOLD with frame_ack=1 enters FLUSH next cycle; frame_valid drops the same edge.
REQ-023 FLUSH: exactly one cycle; pk_valid=1, pk_en=0, word_ready=0; then IDLE with word_cnt=0.
REQ-024 FILL: the idle timer counts cycles without a handshake; reaching TIMEOUT_CYC-1 enters FLUSH and pulses frame_err for one cycle coincident with FLUSH.
REQ-025 frame_ack outside HOLD is ignored.
REQ-026 A handshake on the cycle the timer expires is accepted, the timer restarts, and no abort occurs.
REQ-027 drop_cnt increments by 1 on each cycle with word_valid=1 and word_ready=0; holds at 255.
REQ-028 word_cnt and the idle timer are sized for FRAME_WORDS and TIMEOUT_CYC and cannot wrap.
REQ-029 Outside forwarding and FLUSH cycles: pk_valid=0, pk_en=0, pk_data=0.

Reset
REQ-030 rst=1 at a clock edge forces IDLE; word_cnt, drop_cnt and the timer go to 0; frame_valid and frame_err go to 0. This applies in any state, including mid-FILL or in HOLD.
REQ-031 The first cycle after reset release is a FLUSH-equivalent clear (pk_valid=1, pk_en=0), so the packer never retains stale data.
REQ-032 During rst=1: word_ready=0, and pk_valid/pk_en are 0.

Structure
REQ-033 The shared package holds the state enumeration, the FRAME_WORDS default and the TIMEOUT_CYC default.
REQ-034 The idle timer is the one natural sub-module, frame_idle_timer: parameter TIMEOUT_CYC; inputs clear and run; output expired.
REQ-035 The packer is instantiated by the parent; this block only drives the packer's enable and valid inputs.

Verification
REQ-036 Reset release -> cycle 1: pk_valid=1, pk_en=0; then IDLE with word_ready=1 and word_cnt=0.
REQ-037 240 back-to-back words 0x0001..0x00F0 -> frame_valid=1 the cycle after word 240; word_ready=0; pk_data matches each word on its cycle.
REQ-038 In HOLD, frame_ack held low 100 cycles while word_valid=1 -> frame_valid stays 1; drop_cnt=100; then ack -> one FLUSH cycle, then IDLE.
REQ-039 10 words then silence (TIMEOUT_CYC=16) -> frame_err pulse 15 cycles after the last word, coincident with the FLUSH strobe; word_cnt returns to 0.
REQ-040 rst asserted at word_cnt=120 -> next cycle IDLE, word_cnt=0, frame_valid=0; the following frame completes normally at 240 words.
REQ-041 300 cycles of word_valid=1 in HOLD -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/frame_pack_ctrl_pkg.sv
// Shared types and defaults for the UART-word frame packing controller.
// Holds the FSM state enumeration, the parameter defaults and a counter-width helper.
package frame_pack_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int FRAME_WORDS_DEF = 240;
  localparam int TIMEOUT_CYC_DEF = 50000;
  localparam int DROP_MAX        = 255;

  // Bits needed to hold values 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_idle_timer.sv
// Counts consecutive idle cycles while a frame is filling.
// expired is high during the cycle in which the idle count (including the current cycle) reaches TIMEOUT_CYC-1.
module frame_idle_timer
  import frame_pack_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int            CW   = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 2);

  // r_cnt holds the number of idle cycles already completed before this one.
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = run && (r_cnt == LAST);

endmodule

// File: rtl/frame_pack_ctrl.sv
// Gathers FRAME_WORDS 16-bit words into an external packer, holds the full frame
// until acknowledged, and aborts a stalled frame after an idle timeout.
module frame_pack_ctrl
  import frame_pack_ctrl_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [15:0] pk_data,
  output logic        pk_valid,
  output logic        pk_en,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        frame_err,
  output logic [7:0]  word_cnt,
  output logic [7:0]  drop_cnt,
  output state_t      dbg_state
);

  localparam int             WCW     = cnt_width(FRAME_WORDS);
  localparam logic [WCW-1:0] WC_LAST = WCW'(FRAME_WORDS - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_word_cnt;
  logic [7:0]     r_drop_cnt;
  logic           r_post_rst;
  logic           r_frame_err;

  logic w_accept_ok;
  logic w_hs;
  logic w_last;
  logic w_expired;
  logic w_tmr_clear;
  logic w_tmr_run;

  // Handshake: a word transfers on a cycle where word_valid and word_ready are both high;
  // word_ready never depends on word_valid, and an offer with word_ready low is dropped and counted.
  assign w_accept_ok = !rst && !r_post_rst && ((r_state == ST_IDLE) || (r_state == ST_FILL));
  assign w_hs        = word_valid && w_accept_ok;
  assign w_last      = w_hs && (r_word_cnt == WC_LAST);

  assign w_tmr_clear = w_hs || (r_state != ST_FILL);
  assign w_tmr_run   = (r_state == ST_FILL) && !w_hs;

  frame_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_tmr_clear),
    .run     (w_tmr_run),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) w_state_nxt = w_last ? ST_HOLD : ST_FILL;
      end
      ST_FILL: begin
        if (w_hs) begin
          w_state_nxt = w_last ? ST_HOLD : ST_FILL;
        end else if (w_expired) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_HOLD: begin
        if (frame_ack) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The cycle right after reset release behaves like FLUSH so the packer drops stale data.
  always_comb begin
    word_ready  = w_accept_ok;
    frame_valid = (r_state == ST_HOLD);
    pk_data     = '0;
    pk_valid    = 1'b0;
    pk_en       = 1'b0;
    if (!rst) begin
      if (r_post_rst || (r_state == ST_FLUSH)) begin
        pk_valid = 1'b1;
      end else if (w_hs) begin
        pk_data  = word_in;
        pk_valid = 1'b1;
        pk_en    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_post_rst  <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      r_post_rst  <= 1'b0;
      r_frame_err <= w_expired;
      if (r_state == ST_FLUSH) begin
        r_word_cnt <= '0;
      end else if (w_hs) begin
        r_word_cnt <= r_word_cnt + WCW'(1);
      end
      if (word_valid && !w_accept_ok && (r_drop_cnt != 8'(DROP_MAX))) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign word_cnt  = 8'(r_word_cnt);
  assign drop_cnt  = r_drop_cnt;
  assign frame_err = r_frame_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_frame_pack_ctrl.sv
// Directed bench for frame_pack_ctrl: reset clear, full frames, hold/drop, timeout abort,
// handshake on the expiry cycle, reset mid-frame and drop counter saturation.
module tb_frame_pack_ctrl;
  import frame_pack_ctrl_pkg::*;

  localparam int FW = 240;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] pk_data;
  logic        pk_valid;
  logic        pk_en;
  logic        frame_valid;
  logic        frame_ack;
  logic        frame_err;
  logic [7:0]  word_cnt;
  logic [7:0]  drop_cnt;
  state_t      dbg_state;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];

  frame_pack_ctrl #(
    .FRAME_WORDS (FW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .pk_data     (pk_data),
    .pk_valid    (pk_valid),
    .pk_en       (pk_en),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_err   (frame_err),
    .word_cnt    (word_cnt),
    .drop_cnt    (drop_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n back-to-back words base, base+1, ...; word counter starts at cnt0.
  task automatic send_words(input int n, input logic [15:0] base, input int cnt0);
    logic [15:0] exp_w;
    for (int i = 0; i < n; i++) begin
      word_in    = base + 16'(i);
      word_valid = 1'b1;
      exp_q.push_back(base + 16'(i));
      #1;
      exp_w = exp_q.pop_front();
      chk("fill_ready", 32'(word_ready), 32'd1);
      chk("fill_word_cnt", 32'(word_cnt), 32'(cnt0 + i));
      chk("fill_pk_strobes", 32'({pk_valid, pk_en}), 32'd3);
      chk("fill_pk_data", 32'(pk_data), 32'(exp_w));
      step();
    end
    word_valid = 1'b0;
    word_in    = '0;
  endtask

  initial begin
    rst        = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    frame_ack  = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(word_ready), 32'd0);
    chk("rst_pk_valid", 32'(pk_valid), 32'd0);
    chk("rst_pk_en", 32'(pk_en), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);

    rst = 1'b0;
    #1;
    chk("rel_pk_valid", 32'(pk_valid), 32'd1);
    chk("rel_pk_en", 32'(pk_en), 32'd0);
    chk("rel_ready", 32'(word_ready), 32'd0);
    step();
    chk("idle_ready", 32'(word_ready), 32'd1);
    chk("idle_word_cnt", 32'(word_cnt), 32'd0);
    chk("idle_pk_valid", 32'(pk_valid), 32'd0);
    chk("idle_pk_data", 32'(pk_data), 32'd0);

    // frame_ack outside HOLD has no effect
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("ack_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ack_idle_fv", 32'(frame_valid), 32'd0);

    // frame 1: 0x0001..0x00F0, then hold with offered words
    send_words(FW, 16'h0001, 0);
    word_valid = 1'b1;
    #1;
    chk("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    chk("hold_ready", 32'(word_ready), 32'd0);
    chk("hold_pk_valid", 32'(pk_valid), 32'd0);
    chk("hold_word_cnt", 32'(word_cnt), 32'd240);
    for (int i = 0; i < 100; i++) begin
      chk("hold_fv", 32'(frame_valid), 32'd1);
      step();
    end
    word_valid = 1'b0;
    chk("hold_drop_100", 32'(drop_cnt), 32'd100);
    frame_ack = 1'b1;
    #1;
    chk("ack_fv_still", 32'(frame_valid), 32'd1);
    step();
    frame_ack = 1'b0;
    #1;
    chk("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
    chk("flush_strobes", 32'({pk_valid, pk_en}), 32'd2);
    chk("flush_ready", 32'(word_ready), 32'd0);
    chk("flush_fv", 32'(frame_valid), 32'd0);
    chk("flush_no_err", 32'(frame_err), 32'd0);
    step();
    chk("post_flush_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_flush_cnt", 32'(word_cnt), 32'd0);
    chk("post_flush_ready", 32'(word_ready), 32'd1);
    chk("post_flush_pk", 32'({pk_valid, pk_en}), 32'd0);

    // 10 words then silence: abort 15 clocks after the last accepted word
    send_words(10, 16'h0A00, 0);
    for (int k = 1; k <= 15; k++) begin
      chk("to_no_err", 32'(frame_err), 32'd0);
      chk("to_fill", 32'(dbg_state), 32'(ST_FILL));
      step();
    end
    chk("to_err", 32'(frame_err), 32'd1);
    chk("to_flush", 32'(dbg_state), 32'(ST_FLUSH));
    chk("to_strobes", 32'({pk_valid, pk_en}), 32'd2);
    step();
    chk("to_err_pulse", 32'(frame_err), 32'd0);
    chk("to_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_cnt_clr", 32'(word_cnt), 32'd0);

    // a word on the expiry cycle is accepted and cancels the abort
    send_words(1, 16'h0B00, 0);
    for (int k = 1; k <= 14; k++) begin
      chk("race_fill", 32'(dbg_state), 32'(ST_FILL));
      step();
    end
    word_in    = 16'h0B01;
    word_valid = 1'b1;
    #1;
    chk("race_strobes", 32'({pk_valid, pk_en}), 32'd3);
    chk("race_data", 32'(pk_data), 32'h0B01);
    step();
    word_valid = 1'b0;
    chk("race_state", 32'(dbg_state), 32'(ST_FILL));
    chk("race_cnt", 32'(word_cnt), 32'd2);
    chk("race_no_err", 32'(frame_err), 32'd0);

    // reset in the middle of a frame
    send_words(118, 16'h0C00, 2);
    chk("mid_cnt", 32'(word_cnt), 32'd120);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(word_ready), 32'd0);
    chk("mid_rst_pk", 32'({pk_valid, pk_en}), 32'd0);
    step();
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_cnt", 32'(word_cnt), 32'd0);
    chk("mid_rst_fv", 32'(frame_valid), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_strobes", 32'({pk_valid, pk_en}), 32'd2);
    step();
    chk("mid_rel_ready", 32'(word_ready), 32'd1);

    // frame 2 completes normally, then drop counter saturates in HOLD
    send_words(FW, 16'h1000, 0);
    chk("f2_fv", 32'(frame_valid), 32'd1);
    chk("f2_cnt", 32'(word_cnt), 32'd240);
    word_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 254) chk("drop_254", 32'(drop_cnt), 32'd254);
      if (i == 255) chk("drop_255", 32'(drop_cnt), 32'd255);
      step();
    end
    word_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    chk("f2_fv_hold", 32'(frame_valid), 32'd1);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    #1;
    chk("f2_flush", 32'(dbg_state), 32'(ST_FLUSH));
    step();
    chk("f2_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("f2_cnt_clr", 32'(word_cnt), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
